pipe_mw_stage: RTL and testbench

//   Parametrised MEM->WB pipeline stage with valid/ready flow control, flush,
//   and an optional 1-entry skid buffer. Sits between data-memory access and

---
 rtl/pipe_pkg.sv | 37 +++
 rtl/pipe_slot.sv | 30 +++
 rtl/pipe_mw_stage.sv | 128 ++++++++++++
 tb/tb_pipe_mw_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the MEM->WB pipeline stage: bundle layout helpers
// and the occupancy state encoding.
package pipe_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int RN_W_DEF    = 5;
    localparam int MW_BUNDLE_W = 2 + 2*XLEN_DEF + RN_W_DEF;

    // Bundle layout, MSB first: {wreg, m2reg, mo, alu, rn}
    function automatic int mw_bundle_w(input int xlen, input int rn_w);
        return 2 + 2*xlen + rn_w;
    endfunction

    function automatic int mw_alu_lsb(input int rn_w);
        return rn_w;
    endfunction

    function automatic int mw_mo_lsb(input int xlen, input int rn_w);
        return rn_w + xlen;
    endfunction

    function automatic int mw_m2reg_bit(input int xlen, input int rn_w);
        return rn_w + 2*xlen;
    endfunction

    function automatic int mw_wreg_bit(input int xlen, input int rn_w);
        return rn_w + 2*xlen + 1;
    endfunction

    // Encoding matches {out_valid, skid_valid} so the state is read straight off the slots
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b10,
        FULL  = 2'b11
    } mw_state_e;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline holding slot: a valid bit plus a payload register.
// clear zeroes everything, drop only invalidates and keeps the payload visible.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int W = MW_BUNDLE_W
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         load,
    input  logic         drop,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic         valid,
    output logic [W-1:0] data
);

    always_ff @(posedge clock) begin
        if (!resetn || clear) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= din;
        end else if (drop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_mw_stage.sv
// MEM->WB pipeline stage with valid/ready handshake, flush and an optional
// skid slot that keeps in_ready a pure register output.
module pipe_mw_stage
    import pipe_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RN_W    = 5,
    parameter int SKID_EN = 1
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            mwreg,
    input  logic            mm2reg,
    input  logic [XLEN-1:0] mmo,
    input  logic [XLEN-1:0] malu,
    input  logic [RN_W-1:0] mrn,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            wwreg,
    output logic            wm2reg,
    output logic [XLEN-1:0] wmo,
    output logic [XLEN-1:0] walu,
    output logic [RN_W-1:0] wrn,
    output logic [XLEN-1:0] wdata
);

    localparam int BW        = mw_bundle_w(XLEN, RN_W);
    localparam int ALU_LSB   = mw_alu_lsb(RN_W);
    localparam int MO_LSB    = mw_mo_lsb(XLEN, RN_W);
    localparam int M2REG_BIT = mw_m2reg_bit(XLEN, RN_W);
    localparam int WREG_BIT  = mw_wreg_bit(XLEN, RN_W);

    logic [BW-1:0] in_bundle;
    logic [BW-1:0] out_bundle;
    logic [BW-1:0] out_din;
    logic [BW-1:0] skid_bundle;
    logic          skid_valid;
    logic          out_load;
    logic          out_drop;
    logic          out_clear;
    logic          skid_load;
    logic          skid_clear;
    mw_state_e     state;

    assign in_bundle = {mwreg, mm2reg, mmo, malu, mrn};

    // Steering: flush wins; the skid entry always moves to OUT before any new input
    always_comb begin
        out_load   = 1'b0;
        out_drop   = 1'b0;
        out_clear  = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        out_din    = in_bundle;
        state      = mw_state_e'({out_valid, skid_valid});
        if (flush) begin
            out_clear  = 1'b1;
            skid_clear = 1'b1;
        end else if (SKID_EN != 0) begin
            case (state)
                EMPTY: out_load = in_valid;
                BUSY: begin
                    if (out_ready) begin
                        out_load = in_valid;
                        out_drop = ~in_valid;
                    end else begin
                        skid_load = in_valid;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        out_load   = 1'b1;
                        out_din    = skid_bundle;
                        skid_clear = 1'b1;
                    end
                end
                default: ;
            endcase
        end else begin
            out_load = in_valid & in_ready;
            out_drop = ~(in_valid & in_ready) & out_valid & out_ready;
        end
    end

    pipe_slot #(.W(BW)) u_out (
        .clock  (clock),
        .resetn (resetn),
        .load   (out_load),
        .drop   (out_drop),
        .clear  (out_clear),
        .din    (out_din),
        .valid  (out_valid),
        .data   (out_bundle)
    );

    generate
        if (SKID_EN != 0) begin : g_skid
            pipe_slot #(.W(BW)) u_skid (
                .clock  (clock),
                .resetn (resetn),
                .load   (skid_load),
                .drop   (1'b0),
                .clear  (skid_clear),
                .din    (in_bundle),
                .valid  (skid_valid),
                .data   (skid_bundle)
            );
            assign in_ready = ~skid_valid;
        end else begin : g_noskid
            logic unused_skid;
            assign unused_skid = skid_load ^ skid_clear;
            assign skid_valid  = 1'b0;
            assign skid_bundle = '0;
            assign in_ready    = ~out_valid | out_ready;
        end
    endgenerate

    assign wwreg  = out_valid & out_bundle[WREG_BIT];
    assign wm2reg = out_bundle[M2REG_BIT];
    assign wmo    = out_bundle[MO_LSB +: XLEN];
    assign walu   = out_bundle[ALU_LSB +: XLEN];
    assign wrn    = out_bundle[RN_W-1:0];
    assign wdata  = wm2reg ? wmo : walu;

endmodule

// File: tb/tb_pipe_mw_stage.sv
// Bench for pipe_mw_stage: skid and no-skid builds side by side, each checked
// every cycle against a queue model of the stage, plus directed literal checks.
module tb_pipe_mw_stage;

    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic [31:0] mo;
        logic [31:0] alu;
        logic [4:0]  rn;
    } ent_t;

    logic        clock;
    logic        resetn;
    logic        flush;
    logic        in_valid;
    logic        mwreg;
    logic        mm2reg;
    logic [31:0] mmo;
    logic [31:0] malu;
    logic [4:0]  mrn;
    logic        out_ready;

    logic        ov  [2];
    logic        ir  [2];
    logic        ww  [2];
    logic        wm  [2];
    logic [31:0] wmo_s  [2];
    logic [31:0] walu_s [2];
    logic [31:0] wd  [2];
    logic [4:0]  wrn_s  [2];

    int passed;
    int total;
    bit started;

    // Index 0: skid build (capacity 2), index 1: single-slot build (capacity 1)
    ent_t mq   [2][2];
    int   mcnt [2];
    ent_t held [2];

    pipe_mw_stage #(.XLEN(32), .RN_W(5), .SKID_EN(1)) dut (
        .clock(clock), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[0]),
        .mwreg(mwreg), .mm2reg(mm2reg), .mmo(mmo), .malu(malu), .mrn(mrn),
        .out_valid(ov[0]), .out_ready(out_ready),
        .wwreg(ww[0]), .wm2reg(wm[0]), .wmo(wmo_s[0]), .walu(walu_s[0]),
        .wrn(wrn_s[0]), .wdata(wd[0])
    );

    pipe_mw_stage #(.XLEN(32), .RN_W(5), .SKID_EN(0)) dut0 (
        .clock(clock), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[1]),
        .mwreg(mwreg), .mm2reg(mm2reg), .mmo(mmo), .malu(malu), .mrn(mrn),
        .out_valid(ov[1]), .out_ready(out_ready),
        .wwreg(ww[1]), .wm2reg(wm[1]), .wmo(wmo_s[1]), .walu(walu_s[1]),
        .wrn(wrn_s[1]), .wdata(wd[1])
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    task automatic applyStimulus(input logic v, input logic wr, input logic m2,
                                 input logic [31:0] mo, input logic [31:0] alu, input logic [4:0] rn);
        in_valid = v;
        mwreg    = wr;
        mm2reg   = m2;
        mmo      = mo;
        malu     = alu;
        mrn      = rn;
        @(negedge clock);
    endtask

    function automatic bit model_ready(input int d);
        if (d == 0) return mcnt[0] < 2;
        return (mcnt[1] == 0) || (out_ready == 1'b1);
    endfunction

    // Model advances on each edge; outputs are compared 1 time unit later
    always @(posedge clock) begin
        bit   rdy [2];
        ent_t inc;
        inc = '{wreg: mwreg, m2reg: mm2reg, mo: mmo, alu: malu, rn: mrn};
        for (int d = 0; d < 2; d++) rdy[d] = model_ready(d);
        for (int d = 0; d < 2; d++) begin
            if (!resetn || flush) begin
                mcnt[d] = 0;
                held[d] = '0;
            end else begin
                if (mcnt[d] > 0 && out_ready) begin
                    mq[d][0] = mq[d][1];
                    mcnt[d]--;
                end
                if (in_valid && rdy[d]) begin
                    mq[d][mcnt[d]] = inc;
                    mcnt[d]++;
                end
                if (mcnt[d] > 0) held[d] = mq[d][0];
            end
        end
        #1;
        if (started) begin
            for (int d = 0; d < 2; d++) begin
                checkOutput($sformatf("d%0d out_valid", d), 64'(ov[d]), 64'(mcnt[d] > 0));
                checkOutput($sformatf("d%0d in_ready", d), 64'(ir[d]), 64'(model_ready(d)));
                checkOutput($sformatf("d%0d wwreg", d), 64'(ww[d]), 64'((mcnt[d] > 0) && held[d].wreg));
                checkOutput($sformatf("d%0d wm2reg", d), 64'(wm[d]), 64'(held[d].m2reg));
                checkOutput($sformatf("d%0d wmo", d), 64'(wmo_s[d]), 64'(held[d].mo));
                checkOutput($sformatf("d%0d walu", d), 64'(walu_s[d]), 64'(held[d].alu));
                checkOutput($sformatf("d%0d wrn", d), 64'(wrn_s[d]), 64'(held[d].rn));
                checkOutput($sformatf("d%0d wdata", d), 64'(wd[d]),
                            64'(held[d].m2reg ? held[d].mo : held[d].alu));
            end
        end
    end

    initial begin
        passed    = 0;
        total     = 0;
        mcnt[0]   = 0;
        mcnt[1]   = 0;
        held[0]   = '0;
        held[1]   = '0;
        resetn    = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        started   = 1'b1;

        // Reset with an incoming entry present
        applyStimulus(1, 1, 0, 32'h0, 32'h55, 5'd3);
        applyStimulus(1, 1, 0, 32'h0, 32'h55, 5'd3);
        checkOutput("rst out_valid", 64'(ov[0]), 64'd0);
        checkOutput("rst wwreg", 64'(ww[0]), 64'd0);
        checkOutput("rst walu", 64'(walu_s[0]), 64'd0);
        resetn    = 1'b1;
        out_ready = 1'b1;
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 5'd0);
        checkOutput("post-rst in_ready", 64'(ir[0]), 64'd1);
        checkOutput("post-rst in_ready nsk", 64'(ir[1]), 64'd1);

        // Streaming, no bubbles
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 0, 32'h0, 32'h10 + 32'(i), 5'(i + 1));
            checkOutput($sformatf("stream walu %0d", i), 64'(walu_s[0]), 64'h10 + 64'(i));
            checkOutput($sformatf("stream wrn %0d", i), 64'(wrn_s[0]), 64'(i + 1));
            checkOutput($sformatf("stream valid %0d", i), 64'(ov[0]), 64'd1);
            checkOutput($sformatf("stream in_ready %0d", i), 64'(ir[0]), 64'd1);
            checkOutput($sformatf("stream nsk walu %0d", i), 64'(walu_s[1]), 64'h10 + 64'(i));
        end
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 5'd0);
        checkOutput("stream drained", 64'(ov[0]), 64'd0);

        // Back-pressure into the skid slot
        out_ready = 1'b0;
        applyStimulus(1, 1, 0, 32'h0, 32'hA, 5'd5);
        checkOutput("bp A on out", 64'(walu_s[0]), 64'hA);
        applyStimulus(1, 1, 0, 32'h0, 32'hB, 5'd6);
        checkOutput("bp A held", 64'(walu_s[0]), 64'hA);
        checkOutput("bp in_ready full", 64'(ir[0]), 64'd0);
        out_ready = 1'b1;
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 5'd0);
        checkOutput("bp B on out", 64'(walu_s[0]), 64'hB);
        checkOutput("bp B valid", 64'(ov[0]), 64'd1);
        checkOutput("bp in_ready back", 64'(ir[0]), 64'd1);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 5'd0);
        checkOutput("bp drained", 64'(ov[0]), 64'd0);

        // Flush while full, with an incoming entry that must be dropped
        out_ready = 1'b0;
        applyStimulus(1, 1, 0, 32'h0, 32'hA, 5'd5);
        applyStimulus(1, 1, 0, 32'h0, 32'hB, 5'd6);
        flush = 1'b1;
        applyStimulus(1, 1, 0, 32'h0, 32'hC, 5'd7);
        flush = 1'b0;
        checkOutput("flush out_valid", 64'(ov[0]), 64'd0);
        checkOutput("flush wwreg", 64'(ww[0]), 64'd0);
        checkOutput("flush in_ready", 64'(ir[0]), 64'd1);
        out_ready = 1'b1;
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 5'd0);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 5'd0);
        checkOutput("flush nothing after", 64'(ov[0]), 64'd0);

        // Writeback source mux and bubble qualification
        out_ready = 1'b0;
        applyStimulus(1, 1, 1, 32'hDEADBEEF, 32'h1, 5'd7);
        checkOutput("mux wdata", 64'(wd[0]), 64'hDEADBEEF);
        checkOutput("mux wwreg", 64'(ww[0]), 64'd1);
        out_ready = 1'b1;
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 5'd0);
        checkOutput("bubble out_valid", 64'(ov[0]), 64'd0);
        checkOutput("bubble wwreg", 64'(ww[0]), 64'd0);

        // Single-slot build: comb in_ready and pass-through
        flush = 1'b1;
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 5'd0);
        flush     = 1'b0;
        out_ready = 1'b0;
        applyStimulus(1, 1, 0, 32'h0, 32'h60, 5'd8);
        checkOutput("nsk full in_ready", 64'(ir[1]), 64'd0);
        checkOutput("nsk full walu", 64'(walu_s[1]), 64'h60);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 0, 32'h0, 32'h61 + 32'(i), 5'(9 + i));
            checkOutput($sformatf("nsk pass walu %0d", i), 64'(walu_s[1]), 64'h61 + 64'(i));
            checkOutput($sformatf("nsk pass in_ready %0d", i), 64'(ir[1]), 64'd1);
        end

        // Randomized traffic with occasional flush and reset
        for (int n = 0; n < 600; n++) begin
            out_ready = 1'(($urandom % 3) != 0);
            flush     = 1'(($urandom % 25) == 0);
            resetn    = 1'(($urandom % 80) != 0);
            applyStimulus(1'(($urandom % 4) != 0), 1'($urandom), 1'($urandom),
                          32'($urandom), 32'($urandom), 5'($urandom));
        end
        resetn    = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 5'd0);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 5'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
